subpix_disparity_refine: RTL and testbench

//  Inverse of the sub-pixel interpolator: the interpolator turns a fractional position into a sample value; this block turns

---
 rtl/subpix_disparity_refine_pkg.sv | 16 +
 rtl/subpix_disparity_refine_divider.sv | 67 ++++++
 rtl/subpix_disparity_refine.sv | 142 ++++++++++++++
 tb/tb_subpix_disparity_refine.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/subpix_disparity_refine_pkg.sv
// Shared types for the sub-pixel disparity refinement block.
// Provides the job FSM encoding and the default widths used by the refine stage.
package subpix_disparity_refine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        OUT  = 2'd3
    } spState;

    localparam int DATA_DEPTH_DEF   = 8;
    localparam int DISP_DEPTH_DEF   = 7;
    localparam int SUBPIX_DEPTH_DEF = 5;

endpackage

// File: rtl/subpix_disparity_refine_divider.sv
// Unsigned restoring divider producing Q_W quotient bits of (num << Q_W) / den, one bit per cycle, MSB first.
// The quotient is only exact when num < den; callers override the result otherwise.
module sp_serial_divider #(
    parameter int NUM_W = 9,
    parameter int DEN_W = 12,
    parameter int Q_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quot
);

    localparam int CNT_W = $clog2(Q_W + 1);

    logic [DEN_W-1:0] remReg;
    logic [DEN_W-1:0] denReg;
    logic [Q_W-1:0]   quotReg;
    logic [CNT_W-1:0] cntReg;
    logic             busyReg;
    logic             doneReg;

    logic [DEN_W:0]   shifted;
    logic             fits;
    logic [DEN_W-1:0] remNext;

    always_comb begin
        shifted = {remReg, 1'b0};
        fits    = (shifted >= {1'b0, denReg});
        remNext = fits ? DEN_W'(shifted - {1'b0, denReg}) : DEN_W'(shifted);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remReg  <= '0;
            denReg  <= '0;
            quotReg <= '0;
            cntReg  <= '0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else if (start) begin
            remReg  <= {{(DEN_W-NUM_W){1'b0}}, num};
            denReg  <= den;
            quotReg <= '0;
            cntReg  <= CNT_W'(Q_W);
            busyReg <= 1'b1;
            doneReg <= 1'b0;
        end else if (busyReg) begin
            remReg  <= remNext;
            quotReg <= {quotReg[Q_W-2:0], fits};
            cntReg  <= cntReg - CNT_W'(1);
            if (cntReg == CNT_W'(1)) begin
                busyReg <= 1'b0;
                doneReg <= 1'b1;
            end
        end
    end

    assign busy = busyReg;
    assign done = doneReg;
    assign quot = quotReg;

endmodule

// File: rtl/subpix_disparity_refine.sv
// Parabolic sub-pixel refinement of a WTA disparity: off = (Cm-Cp) / (2*(Cm+Cp-2*C0)),
// emitted as d*2^F + off with degenerate-fit flagging, clamping to half a pixel and saturation.
module subpix_disparity_refine
    import subpix_disparity_refine_pkg::*;
#(
    parameter int dataDepth   = DATA_DEPTH_DEF,
    parameter int dispDepth   = DISP_DEPTH_DEF,
    parameter int subPixDepth = SUBPIX_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [dataDepth-1:0]             costM,
    input  logic [dataDepth-1:0]             cost0,
    input  logic [dataDepth-1:0]             costP,
    input  logic [dispDepth-1:0]             dispIn,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [dispDepth+subPixDepth-1:0] dispOut,
    output logic                             outFlag
);

    localparam int NUM_W = dataDepth + 1;
    localparam int DEN_W = dataDepth + 4;
    localparam int OUT_W = dispDepth + subPixDepth;
    localparam logic [subPixDepth-1:0] HALF_PIX = {1'b1, {(subPixDepth-1){1'b0}}};

    spState stateReg, stateNext;

    logic [dataDepth-1:0] costMReg, cost0Reg, costPReg;
    logic [dispDepth-1:0] dispReg;
    logic                 sgnReg, degenReg, clampReg;
    logic [OUT_W-1:0]     dispOutReg;
    logic                 outFlagReg;

    logic                    sgnComb, degenComb, clampComb;
    logic [NUM_W-1:0]        numComb;
    logic [DEN_W-1:0]        denComb;

    logic                    divStart, divBusy, divDone;
    logic [subPixDepth-1:0]  divQuot;

    logic [subPixDepth-1:0]  offMag;
    logic [OUT_W+1:0]        baseVal, offExt, sumComb;
    logic [OUT_W-1:0]        dispSat;

    // PREP arithmetic: works from the captured costs, so the input bus is free after accept
    always_comb begin
        sgnComb   = (costMReg > costPReg);
        numComb   = sgnComb ? ({1'b0, costMReg} - {1'b0, costPReg})
                            : ({1'b0, costPReg} - {1'b0, costMReg});
        denComb   = (({{(DEN_W-dataDepth){1'b0}}, costMReg} + {{(DEN_W-dataDepth){1'b0}}, costPReg}) << 1)
                  - {2'b00, cost0Reg, 2'b00};
        degenComb = denComb[DEN_W-1] || (denComb == '0);
        clampComb = !degenComb && ({{(DEN_W-NUM_W-1){1'b0}}, numComb, 1'b0} >= denComb);
    end

    sp_serial_divider #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W),
        .Q_W   (subPixDepth)
    ) uDivider (
        .clk   (clk),
        .rst   (rst),
        .start (divStart),
        .num   (numComb),
        .den   (denComb),
        .busy  (divBusy),
        .done  (divDone),
        .quot  (divQuot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stateReg <= IDLE;
        else     stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (in_valid) stateNext = PREP;
            PREP:    stateNext = DIV;
            DIV:     if (divDone && !divBusy) stateNext = OUT;
            OUT:     if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (stateReg == IDLE);
        out_valid = (stateReg == OUT);
        divStart  = (stateReg == PREP);
    end

    // Magnitude is chosen first; the sign is applied afterwards so clamping is symmetric
    always_comb begin
        if (degenReg)      offMag = '0;
        else if (clampReg) offMag = HALF_PIX;
        else               offMag = divQuot;
        baseVal = {2'b00, dispReg, {subPixDepth{1'b0}}};
        offExt  = {{(OUT_W+2-subPixDepth){1'b0}}, offMag};
        sumComb = sgnReg ? (baseVal + offExt) : (baseVal - offExt);
        if (sumComb[OUT_W+1])    dispSat = '0;
        else if (sumComb[OUT_W]) dispSat = '1;
        else                     dispSat = sumComb[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            costMReg   <= '0;
            cost0Reg   <= '0;
            costPReg   <= '0;
            dispReg    <= '0;
            sgnReg     <= 1'b0;
            degenReg   <= 1'b0;
            clampReg   <= 1'b0;
            dispOutReg <= '0;
            outFlagReg <= 1'b0;
        end else begin
            if (stateReg == IDLE && in_valid) begin
                costMReg <= costM;
                cost0Reg <= cost0;
                costPReg <= costP;
                dispReg  <= dispIn;
            end
            if (stateReg == PREP) begin
                sgnReg   <= sgnComb;
                degenReg <= degenComb;
                clampReg <= clampComb;
            end
            if (stateReg == DIV && divDone && !divBusy) begin
                dispOutReg <= dispSat;
                outFlagReg <= degenReg;
            end
        end
    end

    assign dispOut = dispOutReg;
    assign outFlag = outFlagReg;

endmodule

// File: tb/tb_subpix_disparity_refine.sv
// Self-checking bench: directed cases plus randomized jobs against an arithmetic parabolic-fit model.
// Covers latency, backpressure, ignored second offers and reset in the middle of a division.
module tb_subpix_disparity_refine;

    localparam int DD = 8;
    localparam int PD = 7;
    localparam int F  = 5;
    localparam int OW = PD + F;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DD-1:0] costM = '0, cost0 = '0, costP = '0;
    logic [PD-1:0] dispIn = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] dispOut;
    logic          outFlag;

    int testCount = 0;
    int failCount = 0;
    int jobCount  = 0;

    subpix_disparity_refine #(
        .dataDepth   (DD),
        .dispDepth   (PD),
        .subPixDepth (F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .costM     (costM),
        .cost0     (cost0),
        .costP     (costP),
        .dispIn    (dispIn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dispOut   (dispOut),
        .outFlag   (outFlag)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Parabolic fit straight from the formula, with plain integer arithmetic
    task automatic refModel(input int cm, input int c0, input int cp, input int d,
                            output int expDisp, output int expFlag);
        int den, num, mag, off, v;
        den = 2 * (cm + cp - 2 * c0);
        num = (cm > cp) ? cm - cp : cp - cm;
        if (den <= 0) begin
            expFlag = 1;
            mag = 0;
        end else begin
            expFlag = 0;
            if (2 * num >= den) mag = 1 << (F - 1);
            else                mag = (num * (1 << F)) / den;
        end
        off = (cm > cp) ? mag : -mag;
        v = d * (1 << F) + off;
        if (v < 0) v = 0;
        if (v > (1 << OW) - 1) v = (1 << OW) - 1;
        expDisp = v;
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle
    task automatic runJob(input int cm, input int c0, input int cp, input int d,
                          input int holdCycles, input bit offerSecond);
        int expDisp, expFlag, cyc;
        bit seen;
        refModel(cm, c0, cp, d, expDisp, expFlag);
        checkVal("in_ready_idle", {31'b0, in_ready}, 32'd1);
        costM = DD'(cm); cost0 = DD'(c0); costP = DD'(cp); dispIn = PD'(d);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        costM = DD'($urandom); cost0 = DD'($urandom); costP = DD'($urandom); dispIn = PD'($urandom);
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 30) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checkVal("latency", seen ? cyc : -1, 32'd7);
        checkVal("dispOut", {20'b0, dispOut}, expDisp);
        checkVal("outFlag", {31'b0, outFlag}, expFlag);
        for (int h = 0; h < holdCycles; h++) begin
            if (offerSecond) begin
                in_valid = 1'b1;
                costM = DD'($urandom); cost0 = DD'($urandom); costP = DD'($urandom);
            end
            @(posedge clk); #1;
            checkVal("hold_out_valid", {31'b0, out_valid}, 32'd1);
            checkVal("hold_in_ready", {31'b0, in_ready}, 32'd0);
            checkVal("hold_dispOut", {20'b0, dispOut}, expDisp);
            checkVal("hold_outFlag", {31'b0, outFlag}, expFlag);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkVal("post_out_valid", {31'b0, out_valid}, 32'd0);
        checkVal("post_in_ready", {31'b0, in_ready}, 32'd1);
        jobCount++;
        $display("[TB] job %0d cm=%0d c0=%0d cp=%0d d=%0d -> dispOut=%0d flag=%0d (model %0d/%0d)",
                 jobCount, cm, c0, cp, d, dispOut, outFlag, expDisp, expFlag);
    endtask

    initial begin
        int cm, c0, cp, d, mode;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkVal("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkVal("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkVal("rst_dispOut", {20'b0, dispOut}, 32'd0);
        checkVal("rst_outFlag", {31'b0, outFlag}, 32'd0);
        @(posedge clk); #1;

        runJob(10, 4, 6, 20, 0, 1'b0);
        runJob(2, 1, 9, 0, 0, 1'b0);
        runJob(5, 5, 5, 33, 0, 1'b0);
        runJob(3, 9, 4, 33, 0, 1'b0);
        runJob(20, 0, 0, 5, 0, 1'b0);
        runJob(20, 0, 0, 127, 0, 1'b0);
        runJob(0, 0, 20, 127, 0, 1'b0);
        runJob(255, 0, 255, 127, 0, 1'b0);

        runJob(10, 4, 6, 20, 10, 1'b1);
        runJob(2, 1, 9, 64, 0, 1'b0);

        // Reset lands in the third division cycle; nothing from that job may surface
        costM = 8'd40; cost0 = 8'd3; costP = 8'd11; dispIn = 7'd50;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkVal("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkVal("midrst_dispOut", {20'b0, dispOut}, 32'd0);
        checkVal("midrst_outFlag", {31'b0, outFlag}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkVal("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checkVal("midrst_no_stale", {31'b0, out_valid}, 32'd0);
        end
        runJob(7, 2, 3, 90, 0, 1'b0);

        for (int j = 0; j < 40; j++) begin
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                cm = $urandom_range(0, 255);
                c0 = $urandom_range(0, 255);
                cp = $urandom_range(0, 255);
            end else begin
                c0 = $urandom_range(0, 100);
                cm = c0 + $urandom_range(0, 155);
                cp = c0 + $urandom_range(0, 155);
            end
            d = $urandom_range(0, 127);
            runJob(cm, c0, cp, d, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
